// File: rtl/trigger_deadlock_pkg.sv
// Shared definitions for the trigger deadlock reporter: FSM state encoding,
// timestamp width and the lowest-set-bit helper used to build report_idx.
package trigger_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COUNT      = 2'd1,
    ST_REPORT     = 2'd2,
    ST_WAIT_CLEAR = 2'd3
  } dl_state_e;

  localparam int TS_W = 32;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [4:0] first_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && vec[i]) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/trigger_deadlock_run_counter.sv
// Saturating consecutive-cycle counter for the deadlock reporter.
// clr has priority over inc; hit flags the last cycle before the threshold.
module trigger_deadlock_run_counter #(
  parameter int THRESHOLD = 16,
  localparam int CNT_W = $clog2(THRESHOLD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count consecutive increment requests, holding at THRESHOLD.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != SAT_VAL)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
  assign hit = (cnt_q == HIT_VAL);

endmodule

// File: rtl/trigger_hls_deadlock_reporter.sv
// Deadlock reporter: turns a block condition that persists for THRESHOLD
// consecutive cycles into one report (mask + lowest index) held on a
// valid/ready handshake, plus a sticky deadlock_seen flag.
// Optional feature macro: TRIGGER_DEADLOCK_TIMESTAMP_EN adds a free-running
// 32-bit cycle counter whose value at detection is reported.
module trigger_hls_deadlock_reporter
  import trigger_deadlock_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int THRESHOLD = 16
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUM_SRC-1:0]                            block_sigs,
  input  logic                                          clear_sticky,
  output logic                                          report_valid,
  input  logic                                          report_ready,
  output logic [NUM_SRC-1:0]                            report_mask,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] report_idx,
  output logic                                          deadlock_seen
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]                               report_timestamp
`endif
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(THRESHOLD);

  dl_state_e        state_q;
  logic             valid_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [IDX_W-1:0] idx_q;
  logic             seen_q;
  logic             seen_d;

  logic             any_block;
  logic             run_inc;
  logic             run_clr;
  logic             run_hit;
  logic             run_sat;
  logic [CNT_W-1:0] run_cnt;
  logic             detect;

  assign any_block = |block_sigs;

  // Only IDLE and COUNT accumulate a run; every other case restarts it, so a
  // single unblocked cycle (or leaving the counting states) clears the count.
  assign run_sat = (run_cnt == SAT_VAL);
  assign run_inc = any_block && !run_sat &&
                   ((state_q == ST_IDLE) || (state_q == ST_COUNT));
  assign run_clr = !run_inc;
  assign detect  = (state_q == ST_COUNT) && any_block && run_hit;

  trigger_deadlock_run_counter #(
    .THRESHOLD (THRESHOLD)
  ) u_run_counter (
    .clock (clock),
    .reset (reset),
    .inc   (run_inc),
    .clr   (run_clr),
    .cnt   (run_cnt),
    .hit   (run_hit)
  );

  // Report FSM with registered valid/mask/idx outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_block) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (!any_block) begin
            state_q <= ST_IDLE;
          end else if (detect) begin
            state_q <= ST_REPORT;
            valid_q <= 1'b1;
            mask_q  <= block_sigs;
            idx_q   <= IDX_W'(first_set_idx(32'(block_sigs)));
          end
        end
        ST_REPORT: begin
          // block_sigs is deliberately ignored until the report is taken.
          if (report_ready) begin
            state_q <= ST_WAIT_CLEAR;
            valid_q <= 1'b0;
          end
        end
        ST_WAIT_CLEAR: begin
          // One report per episode: rearm only after the block goes away.
          if (!any_block) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag next state: detection beats a same-cycle clear.
  always_comb begin
    seen_d = seen_q;
    if (clear_sticky) seen_d = 1'b0;
    if (detect)       seen_d = 1'b1;
  end

  // Sticky deadlock flag register.
  always_ff @(posedge clock) begin
    if (reset) seen_q <= 1'b0;
    else       seen_q <= seen_d;
  end

  assign report_valid  = valid_q;
  assign report_mask   = mask_q;
  assign report_idx    = idx_q;
  assign deadlock_seen = seen_q;

`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] rts_q;

  // Free-running cycle counter, wrapping modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  // Capture the cycle count of the detection cycle.
  always_ff @(posedge clock) begin
    if (reset)       rts_q <= '0;
    else if (detect) rts_q <= ts_q;
  end

  assign report_timestamp = rts_q;
`endif

endmodule

// File: tb/tb_trigger_hls_deadlock_reporter.sv
// Self-checking bench for trigger_hls_deadlock_reporter (NUM_SRC=4,
// THRESHOLD=16). Directed scenarios plus randomized bursts checked against a
// cycle-level behavioural model of the report rules.
`timescale 1ns/1ps
module tb_trigger_hls_deadlock_reporter;

  localparam int NUM_SRC   = 4;
  localparam int THRESHOLD = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   block_sigs = '0;
  logic         clear_sticky = 1'b0;
  logic         report_ready = 1'b0;
  logic         report_valid;
  logic [3:0]   report_mask;
  logic [1:0]   report_idx;
  logic         deadlock_seen;
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
  logic [31:0]  report_timestamp;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_run;
  bit          m_pend;
  bit          m_wait;
  logic [3:0]  m_mask;
  int          m_idx;
  bit          m_seen;
  logic [31:0] m_ts;
  logic [31:0] m_rts;

  always #5 clock = ~clock;

  trigger_hls_deadlock_reporter #(
    .NUM_SRC   (NUM_SRC),
    .THRESHOLD (THRESHOLD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .block_sigs    (block_sigs),
    .clear_sticky  (clear_sticky),
    .report_valid  (report_valid),
    .report_ready  (report_ready),
    .report_mask   (report_mask),
    .report_idx    (report_idx),
    .deadlock_seen (deadlock_seen)
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
    ,
    .report_timestamp (report_timestamp)
`endif
  );

  function automatic int lowest(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction

  // One clock of the reporting rules: a run of THRESHOLD blocked cycles
  // produces one report, held until taken, then nothing until unblocked.
  task automatic model(input logic [3:0] b, input logic c, input logic r, input logic rs);
    logic [31:0] ts_now;
    if (rs) begin
      m_run = 0; m_pend = 0; m_wait = 0; m_mask = '0; m_idx = 0;
      m_seen = 0; m_ts = '0; m_rts = '0;
    end else begin
      ts_now = m_ts;
      m_ts   = m_ts + 32'd1;
      if (c) m_seen = 0;
      if (m_pend) begin
        if (r) begin m_pend = 0; m_wait = 1; end
      end else if (m_wait) begin
        if (b == 4'd0) m_wait = 0;
      end else if (b != 4'd0) begin
        m_run++;
        if (m_run == THRESHOLD) begin
          m_pend = 1; m_mask = b; m_idx = lowest(b); m_seen = 1;
          m_rts = ts_now; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] b;
    logic c, r, rs;
    b = block_sigs; c = clear_sticky; r = report_ready; rs = reset;
    @(posedge clock); #1;
    model(b, c, r, rs);
  endtask

  task automatic test_reset();
    reset = 1'b1; block_sigs = 4'b1111; report_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; block_sigs = '0;
    total++;
    if (report_valid !== 1'b0 || report_mask !== 4'd0 || report_idx !== 2'd0 ||
        deadlock_seen !== 1'b0) begin
      bad++;
      $display("FAIL reset: got v=%b m=%b i=%0d s=%b, want all 0",
               report_valid, report_mask, report_idx, deadlock_seen);
    end
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
    total++;
    if (report_timestamp !== 32'd0) begin
      bad++;
      $display("FAIL reset_ts: got %0d want 0", report_timestamp);
    end
`endif
  endtask

  task automatic test_basic();
    int nvalid = 0;
    int first  = -1;
    report_ready = 1'b1;
    for (int c = 0; c <= 45; c++) begin
      block_sigs = (c >= 10 && c <= 40) ? 4'b0100 : 4'b0000;
      tick();
      if (report_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = c + 1;
        total++;
        if (report_mask !== 4'b0100 || report_idx !== 2'd2 || deadlock_seen !== 1'b1) begin
          bad++;
          $display("FAIL basic_data: got m=%b i=%0d s=%b want m=0100 i=2 s=1",
                   report_mask, report_idx, deadlock_seen);
        end
      end
    end
    total++;
    if (nvalid != 1 || first != 26) begin
      bad++;
      $display("FAIL basic_timing: got %0d valid cycles first=%0d, want 1 at 26", nvalid, first);
    end
  endtask

  task automatic test_restart();
    int nvalid = 0;
    int first  = -1;
    report_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      block_sigs = (c < 15 || (c >= 16 && c < 32)) ? 4'b0001 : 4'b0000;
      tick();
      if (report_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = c + 1;
      end
    end
    total++;
    if (nvalid != 1 || first != 32) begin
      bad++;
      $display("FAIL restart: got %0d valid cycles first=%0d, want 1 at 32", nvalid, first);
    end
  endtask

  task automatic test_backpressure();
    report_ready = 1'b0;
    block_sigs   = 4'b0001;
    for (int c = 0; c < 16; c++) tick();
    block_sigs = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      total++;
      if (report_valid !== 1'b1 || report_mask !== 4'b0001 || report_idx !== 2'd0) begin
        bad++;
        $display("FAIL hold c=%0d: got v=%b m=%b i=%0d want v=1 m=0001 i=0",
                 c, report_valid, report_mask, report_idx);
      end
      tick();
    end
    report_ready = 1'b1;
    tick();
    total++;
    if (report_valid !== 1'b0 || report_mask !== 4'b0001) begin
      bad++;
      $display("FAIL handshake: got v=%b m=%b want v=0 m=0001", report_valid, report_mask);
    end
    block_sigs = '0;
    tick(); tick();
  endtask

  task automatic test_sticky();
    report_ready = 1'b0;
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    total++;
    if (deadlock_seen !== 1'b0) begin
      bad++;
      $display("FAIL sticky_pre_clear: got %b want 0", deadlock_seen);
    end
    block_sigs = 4'b1010;
    for (int c = 0; c < 16; c++) begin
      clear_sticky = (c == 15);
      tick();
    end
    clear_sticky = 1'b0;
    total++;
    if (deadlock_seen !== 1'b1 || report_valid !== 1'b1 || report_idx !== 2'd1 ||
        report_mask !== 4'b1010) begin
      bad++;
      $display("FAIL sticky_set_wins: got s=%b v=%b i=%0d m=%b want s=1 v=1 i=1 m=1010",
               deadlock_seen, report_valid, report_idx, report_mask);
    end
    report_ready = 1'b1; block_sigs = '0;
    tick(); tick(); tick();
    total++;
    if (deadlock_seen !== 1'b1 || report_idx !== 2'd1) begin
      bad++;
      $display("FAIL sticky_keep: got s=%b i=%0d want s=1 i=1", deadlock_seen, report_idx);
    end
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    total++;
    if (deadlock_seen !== 1'b0) begin
      bad++;
      $display("FAIL sticky_clear: got %b want 0", deadlock_seen);
    end
  endtask

  task automatic test_reset_mid();
    report_ready = 1'b0;
    block_sigs   = 4'b0001;
    for (int c = 0; c < 16; c++) tick();
    total++;
    if (report_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got v=%b want 1", report_valid);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (report_valid !== 1'b0 || report_mask !== 4'd0 || report_idx !== 2'd0 ||
        deadlock_seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b m=%b i=%0d s=%b want all 0",
               report_valid, report_mask, report_idx, deadlock_seen);
    end
    block_sigs = 4'b0010;
    for (int c = 0; c < 15; c++) tick();
    total++;
    if (report_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_early: got v=%b want 0 after 15 cycles", report_valid);
    end
    tick();
    total++;
    if (report_valid !== 1'b1 || report_mask !== 4'b0010 || report_idx !== 2'd1) begin
      bad++;
      $display("FAIL mid_fresh: got v=%b m=%b i=%0d want v=1 m=0010 i=1",
               report_valid, report_mask, report_idx);
    end
    report_ready = 1'b1; block_sigs = '0;
    tick(); tick();
  endtask

`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
  task automatic test_timestamp();
    bit seen_rep = 0;
    reset = 1'b1; block_sigs = '0; report_ready = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 130; c++) begin
      block_sigs = (c >= 100 && c < 120) ? 4'b0100 : 4'b0000;
      tick();
      if (report_valid === 1'b1) begin
        seen_rep = 1;
        total++;
        if (report_timestamp !== 32'd115) begin
          bad++;
          $display("FAIL timestamp: got %0d want 115", report_timestamp);
        end
      end
    end
    total++;
    if (!seen_rep) begin
      bad++;
      $display("FAIL timestamp_report: got no report want one");
    end
  endtask
`endif

  task automatic test_random();
    int         left = 0;
    logic [3:0] cur  = '0;
    for (int n = 0; n < 3000; n++) begin
      if (left == 0) begin
        if ($urandom_range(1, 0) == 0) begin
          cur = '0; left = $urandom_range(5, 1);
        end else begin
          cur = 4'($urandom_range(15, 1)); left = $urandom_range(30, 5);
        end
      end else if (cur != 0 && $urandom_range(7, 0) == 0) begin
        cur = 4'($urandom_range(15, 1));
      end
      left--;
      block_sigs   = cur;
      report_ready = ($urandom_range(2, 0) != 0);
      clear_sticky = ($urandom_range(19, 0) == 0);
      reset        = ($urandom_range(399, 0) == 0);
      tick();
      total++;
      if (report_valid !== m_pend || report_mask !== m_mask ||
          report_idx !== 2'(m_idx) || deadlock_seen !== m_seen) begin
        bad++;
        $display("FAIL random n=%0d: got v=%b m=%b i=%0d s=%b want v=%b m=%b i=%0d s=%b",
                 n, report_valid, report_mask, report_idx, deadlock_seen,
                 m_pend, m_mask, m_idx, m_seen);
      end
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
      total++;
      if (report_timestamp !== m_rts) begin
        bad++;
        $display("FAIL random_ts n=%0d: got %0d want %0d", n, report_timestamp, m_rts);
      end
`endif
    end
    reset = 1'b0; clear_sticky = 1'b0;
  endtask

  initial begin
    model('0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_basic();
    test_restart();
    test_backpressure();
    test_sticky();
    test_reset_mid();
`ifdef TRIGGER_DEADLOCK_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
